// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx: host-to-device PS/2 byte transmitter.
// Pulls PS2_CLK low to inhibit and then sends a request-to-send.
// Shifts out the byte, then odd parity and the stop bit.
// Checks the device ACK and reports the outcome with a one-cycle done pulse.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 10000,
    parameter int START_TIMEOUT_CYCLES = 1500000,
    parameter int XFER_TIMEOUT_CYCLES  = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_FIRST,
        SHIFT,
        ACK,
        WAIT_IDLE,
        FAIL
    } state_t;

    localparam logic [20:0] CNT_MAX      = '1;
    localparam logic [20:0] INHIBIT_LAST = 21'(INHIBIT_CYCLES - 1);
    localparam logic [20:0] START_LAST   = 21'(START_TIMEOUT_CYCLES - 1);
    localparam logic [20:0] XFER_LAST    = 21'(XFER_TIMEOUT_CYCLES - 1);

    state_t      state, state_n;
    logic [20:0] cnt, cnt_n;
    logic [8:0]  shreg, shreg_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic        data_oe_n, clk_oe_n, done_n, ack_ok_n, error_n;
    logic        clk_meta, clk_sync, clk_prev, data_meta, data_sync;
    logic        fall;

    // Two-flop synchronisers on both pins, plus one extra clock stage for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk_i;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data_i;
            data_sync <= data_meta;
        end
    end

    assign fall     = clk_prev & ~clk_sync;
    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // State, counters and all line/status outputs are registered so the pins never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '1;
            bit_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            done        <= done_n;
            ack_ok      <= ack_ok_n;
            error       <= error_n;
        end
    end

    // Next-state logic. Data only changes right after a detected falling edge, while the device holds clock low.
    always_comb begin
        state_n   = state;
        cnt_n     = (cnt == CNT_MAX) ? cnt : cnt + 21'd1;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        data_oe_n = ps2_data_oe;
        done_n    = 1'b0;
        ack_ok_n  = 1'b0;
        error_n   = 1'b0;

        case (state)
            IDLE: begin
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    shreg_n = {~^tx_data, tx_data};
                    cnt_n   = '0;
                    state_n = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt >= INHIBIT_LAST) begin
                    data_oe_n = 1'b1;
                    state_n   = REQ;
                end
            end
            REQ: begin
                cnt_n   = '0;
                state_n = WAIT_FIRST;
            end
            WAIT_FIRST: begin
                if (fall) begin
                    data_oe_n = ~shreg[0];
                    shreg_n   = {1'b1, shreg[8:1]};
                    bit_cnt_n = 4'd1;
                    cnt_n     = '0;
                    state_n   = SHIFT;
                end else if (cnt >= START_LAST) begin
                    state_n = FAIL;
                end
            end
            SHIFT: begin
                if (cnt >= XFER_LAST) begin
                    state_n = FAIL;
                end else if (fall) begin
                    if (bit_cnt == 4'd9) begin
                        data_oe_n = 1'b0;
                        state_n   = ACK;
                    end else begin
                        data_oe_n = ~shreg[0];
                        shreg_n   = {1'b1, shreg[8:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            ACK: begin
                if (cnt >= XFER_LAST) begin
                    state_n = FAIL;
                end else if (fall) begin
                    state_n = data_sync ? FAIL : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (cnt >= XFER_LAST) begin
                    state_n = FAIL;
                end else if (clk_sync && data_sync) begin
                    done_n   = 1'b1;
                    ack_ok_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            FAIL: begin
                data_oe_n = 1'b0;
                state_n   = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_n == FAIL && state != FAIL) begin
            data_oe_n = 1'b0;
            done_n    = 1'b1;
            error_n   = 1'b1;
        end

        clk_oe_n = (state_n == INHIBIT) || (state_n == REQ);
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// tb_ps2_host_tx: directed bench with a PS/2 device model on wired-AND lines.
module tb_ps2_host_tx;

    localparam int INH      = 100;
    localparam int START_TO = 500;
    localparam int XFER_TO  = 2000;
    localparam int HP       = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_i, ps2_data_i;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done, ack_ok, error;

    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;

    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    int err_count   = 0;
    int check_count = 0;

    int         cyc = 0;
    int         inh_run = 0;
    int         req_run = 0;
    int         wf_cyc = 0;
    int         done_cyc = 0;
    int         done_count = 0;
    logic       mon_clear = 1'b0;
    logic       prev_req = 1'b0;
    logic       prev_done = 1'b0;
    logic [1:0] after_done_oe = 2'b00;
    logic       last_ack = 1'b0;
    logic       last_err = 1'b0;

    logic [9:0] bits;
    logic       start_bit;
    logic       rts;
    int         base;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(START_TO),
        .XFER_TIMEOUT_CYCLES (XFER_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Monitor: inhibit/request lengths, WAIT_FIRST entry, done pulses and the line state after done.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (mon_clear) begin
            inh_run <= 0;
            req_run <= 0;
        end else begin
            if (ps2_clk_oe && !ps2_data_oe) inh_run <= inh_run + 1;
            if (ps2_clk_oe && ps2_data_oe)  req_run <= req_run + 1;
        end
        if (prev_req && !ps2_clk_oe && ps2_data_oe) wf_cyc <= cyc;
        if (done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
            last_ack   <= ack_ok;
            last_err   <= error;
        end
        if (prev_done) after_done_oe <= {ps2_clk_oe, ps2_data_oe};
        prev_req  <= ps2_clk_oe && ps2_data_oe;
        prev_done <= done;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] d);
        @(negedge clk); #1;
        mon_clear = 1'b1;
        @(negedge clk); #1;
        mon_clear = 1'b0;
        tx_data   = d;
        tx_valid  = 1'b1;
        @(negedge clk); #1;
        tx_valid  = 1'b0;
    endtask

    task automatic wait_rts(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < INH + 20 && !ok; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) ok = 1'b1;
        end
        check_output("rts_seen", 32'(ok), 32'd1);
    endtask

    task automatic device_xfer(input logic give_ack, input int ack_hold, input int done_base,
                               output logic [9:0] seen, output logic sbit);
        logic ok;
        seen = '1;
        sbit = 1'b1;
        wait_rts(ok);
        if (ok) begin
            repeat (10) @(negedge clk);
            sbit = ps2_data_i;
            for (int k = 1; k <= 11; k++) begin
                if (k == 11) begin
                    if (give_ack) dev_data = 1'b0;
                    repeat (HP / 2) @(negedge clk);
                end
                dev_clk = 1'b0;
                repeat (HP) @(negedge clk);
                dev_clk = 1'b1;
                if (k <= 10) seen[k-1] = ps2_data_i;
                repeat (HP) @(negedge clk);
            end
            repeat (ack_hold) @(negedge clk);
            if (give_ack) check_output("no_done_before_idle", 32'(done_count), 32'(done_base));
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_done(input int done_base, input int limit, input string tag);
        int n = 0;
        while (done_count == done_base && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_done_seen"}, 32'(done_count != done_base), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    // Watchdog so a stuck transfer still ends the run.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        repeat (3) @(negedge clk);
        check_output("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done_ack_err", 32'({done, ack_ok, error}), 32'd0);
        check_output("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // 0xED with an immediate ACK release.
        base = done_count;
        apply_stimulus(8'hED);
        device_xfer(1'b1, 0, base, bits, start_bit);
        wait_done(base, 50, "ed");
        check_output("ed_inhibit_len", 32'(inh_run), 32'(INH));
        check_output("ed_req_len", 32'(req_run), 32'd1);
        check_output("ed_start_bit", 32'(start_bit), 32'd0);
        check_output("ed_bits", 32'(bits), 32'h3ED);
        check_output("ed_done_count", 32'(done_count), 32'(base + 1));
        check_output("ed_ack_ok", 32'(last_ack), 32'd1);
        check_output("ed_error", 32'(last_err), 32'd0);
        check_output("ed_oe_after", 32'(after_done_oe), 32'd0);
        check_output("ed_tx_ready", 32'(tx_ready), 32'd1);

        // 0xFF with the device holding data low long after the ACK edge.
        base = done_count;
        apply_stimulus(8'hFF);
        device_xfer(1'b1, 200, base, bits, start_bit);
        wait_done(base, 50, "ff");
        check_output("ff_bits", 32'(bits), 32'h3FF);
        check_output("ff_done_count", 32'(done_count), 32'(base + 1));
        check_output("ff_ack_ok", 32'(last_ack), 32'd1);
        check_output("ff_error", 32'(last_err), 32'd0);

        // Device never clocks after request-to-send.
        base = done_count;
        apply_stimulus(8'h12);
        wait_done(base, INH + START_TO + 50, "to");
        check_output("to_latency", 32'(done_cyc - wf_cyc), 32'(START_TO));
        check_output("to_error", 32'(last_err), 32'd1);
        check_output("to_ack_ok", 32'(last_ack), 32'd0);
        check_output("to_oe_after", 32'(after_done_oe), 32'd0);

        // NACK: data left high on the 11th edge.
        base = done_count;
        apply_stimulus(8'hAA);
        device_xfer(1'b0, 0, base, bits, start_bit);
        wait_done(base, 50, "nack");
        check_output("nack_bits", 32'(bits), 32'h3AA);
        check_output("nack_error", 32'(last_err), 32'd1);
        check_output("nack_ack_ok", 32'(last_ack), 32'd0);
        check_output("nack_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

        // tx_valid while busy must be ignored.
        base = done_count;
        apply_stimulus(8'hF4);
        fork
            device_xfer(1'b1, 0, base, bits, start_bit);
            begin
                repeat (300) @(negedge clk);
                check_output("busy_mid_xfer", 32'(busy), 32'd1);
                #1;
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk); #1;
                tx_valid = 1'b0;
            end
        join
        wait_done(base, 50, "busy");
        check_output("busy_bits", 32'(bits), 32'h2F4);
        check_output("busy_ack_ok", 32'(last_ack), 32'd1);
        repeat (150) @(negedge clk);
        check_output("busy_one_done", 32'(done_count), 32'(base + 1));
        check_output("busy_idle_after", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of the shift phase.
        base = done_count;
        apply_stimulus(8'hF4);
        wait_rts(rts);
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            dev_clk = 1'b0;
            repeat (HP) @(negedge clk);
            dev_clk = 1'b1;
            repeat (HP) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (6) @(negedge clk);
        check_output("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        #1 rst = 1'b0;
        #1;
        check_output("rst_mid_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        dev_clk = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_output("post_rst_tx_ready", 32'(tx_ready), 32'd1);
        check_output("post_rst_busy", 32'(busy), 32'd0);
        check_output("post_rst_no_done", 32'(done_count), 32'(base));
        apply_stimulus(8'hF4);
        device_xfer(1'b1, 0, base, bits, start_bit);
        wait_done(base, 50, "rerun");
        check_output("rerun_bits", 32'(bits), 32'h2F4);
        check_output("rerun_ack_ok", 32'(last_ack), 32'd1);
        check_output("rerun_error", 32'(last_err), 32'd0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
